// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state encoding and divide-by-zero constants for alu_seq
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_SUBI = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // DIVU by zero fills the quotient with this bit; REMU by zero yields a
    // because the restoring loop never subtracts a zero divisor's remainder away.
    localparam logic DIVZ_QUOT_BIT = 1'b1;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative shift-add multiply and restoring unsigned divide/remainder
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             running_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_mul_q, is_rem_q, divz_q;
    // acc: product (MUL) or partial remainder (DIV); x: multiplicand or dividend/quotient; y: multiplier or divisor
    logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
    logic [WIDTH:0]   rem_sh, diff;

    always_comb begin
        acc_d  = acc_q;
        x_d    = x_q;
        y_d    = y_q;
        rem_sh = {acc_q, x_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, y_q};
        if (is_mul_q) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
        end else if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = rem_sh[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done = running_q && (cnt_q == '0);

    always_comb begin
        if (is_mul_q || is_rem_q) begin
            result = acc_d;
        end else if (divz_q) begin
            result = {WIDTH{DIVZ_QUOT_BIT}};
        end else begin
            result = x_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            is_mul_q  <= 1'b0;
            is_rem_q  <= 1'b0;
            divz_q    <= 1'b0;
            acc_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            cnt_q     <= CNT_W'(WIDTH - 1);
            is_mul_q  <= (op == OP_MUL);
            is_rem_q  <= (op == OP_REMU);
            divz_q    <= (b == '0);
            acc_q     <= '0;
            x_q       <= a;
            y_q       <= b;
        end else if (running_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and optional iterative mul/div (ALU_MULDIV_EN)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IMM_W = 4,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             carry,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic [WIDTH:0]   ext_sum, imm_ext;
    logic             is_iter;

    assign imm_ext = {{(WIDTH + 1 - IMM_W){1'b0}}, b[IMM_W-1:0]};

`ifdef ALU_MULDIV_EN
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    assign is_iter = (op_type == OP_MUL) || (op_type == OP_DIVU) || (op_type == OP_REMU);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (reset),
        .start  (in_valid && in_ready && is_iter),
        .op     (op_type),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .result (iter_result)
    );
`else
    assign is_iter = 1'b0;
`endif

    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        ext_sum   = '0;
        case (op_type)
            OP_ADD:  begin ext_sum = {1'b0, a} + {1'b0, b}; sc_result = ext_sum[WIDTH-1:0]; sc_carry = ext_sum[WIDTH]; end
            OP_SUB:  begin ext_sum = {1'b0, a} - {1'b0, b}; sc_result = ext_sum[WIDTH-1:0]; sc_carry = ext_sum[WIDTH]; end
            OP_ADDI: begin ext_sum = {1'b0, a} + imm_ext;   sc_result = ext_sum[WIDTH-1:0]; sc_carry = ext_sum[WIDTH]; end
            OP_SUBI: begin ext_sum = {1'b0, a} - imm_ext;   sc_result = ext_sum[WIDTH-1:0]; sc_carry = ext_sum[WIDTH]; end
            OP_OR:   sc_result = a | b;
            OP_AND:  sc_result = a & b;
            OP_SLTU: sc_result = {{(WIDTH - 1){1'b0}}, (a < b)};
            OP_SLL:  sc_result = a << b[SH_W-1:0];
            OP_SRL:  sc_result = a >> b[SH_W-1:0];
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter) begin
                        state_d = ST_BUSY;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = sc_result;
                        carry_d  = sc_carry;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            ST_BUSY: begin
                if (iter_done) begin
                    state_d  = ST_DONE;
                    result_d = iter_result;
                    carry_d  = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign alu_result = result_q;
    assign carry      = carry_q;
    assign zero       = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq covering reset, all op groups, latency and back-pressure
module tb_alu_seq;

    localparam int W = 16;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, alu_result;
    logic [3:0]   op_type;
    logic         zero, carry, busy;

    int checks   = 0;
    int failures = 0;

    logic [16:0] exp_q[$];
    int          lat_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op_type    (op_type),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .zero       (zero),
        .carry      (carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] r;
        logic [15:0] p;
        r = 17'd0;
        p = x * y;
        case (op)
            4'd0:  r = {1'b0, x} + {1'b0, y};
            4'd1:  r = {1'b0, x} - {1'b0, y};
            4'd2:  r = {1'b0, x | y};
            4'd3:  r = {1'b0, x & y};
            4'd4:  r = {16'd0, (x < y)};
            4'd5:  r = {1'b0, x << y[3:0]};
            4'd6:  r = {1'b0, x >> y[3:0]};
            4'd7:  r = {1'b0, x} + {13'd0, y[3:0]};
            4'd8:  r = {1'b0, x} - {13'd0, y[3:0]};
            4'd9:  r = MD ? {1'b0, p} : 17'd0;
            4'd10: r = MD ? {1'b0, (y == 16'd0) ? 16'hFFFF : x / y} : 17'd0;
            4'd11: r = MD ? {1'b0, (y == 16'd0) ? x : x % y} : 17'd0;
            default: r = 17'd0;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                          input bit hold, input int stall, input string name);
        logic [16:0] exp_v;
        int          exp_lat;
        int          lat;
        bit          reaccept;
        @(negedge clk);
        a = av; b = bv; op_type = op; in_valid = 1'b1; out_ready = 1'b0;
        exp_q.push_back(model(op, av, bv));
        lat_q.push_back((MD && op >= 4'd9 && op <= 4'd11) ? W + 1 : 1);
        lat = 0;
        reaccept = 1'b0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            a = 16'($urandom);
            b = 16'($urandom);
            if (!hold) in_valid = 1'b0;
            else if (in_ready !== 1'b0) reaccept = 1'b1;
        end
        exp_v   = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (alu_result !== exp_v[15:0] || carry !== exp_v[16] || zero !== (exp_v[15:0] == 16'd0)) begin
            failures++;
            $display("FAIL %s result: got %h c=%b z=%b, expected %h c=%b z=%b", name, alu_result, carry, zero,
                     exp_v[15:0], exp_v[16], (exp_v[15:0] == 16'd0));
        end
        if (hold) begin
            checks++;
            if (reaccept) begin
                failures++;
                $display("FAIL %s held in_valid: in_ready seen high during op, expected low", name);
            end
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== exp_v[15:0] || carry !== exp_v[16]) begin
                failures++;
                $display("FAIL %s stall%0d: got v=%b rdy=%b %h c=%b, expected v=1 rdy=0 %h c=%b", name, i,
                         out_valid, in_ready, alu_result, carry, exp_v[15:0], exp_v[16]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s handoff: got v=%b rdy=%b busy=%b, expected v=0 rdy=1 busy=0", name,
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_type = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 16'd0 || zero !== 1'b1 ||
            carry !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b v=%b res=%h z=%b c=%b busy=%b, expected 1 0 0000 1 0 0",
                     in_ready, out_valid, alu_result, zero, carry, busy);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_out_ready: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        a = 16'h0123; b = 16'h0045; op_type = 4'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_result !== 16'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mul: got rdy=%b v=%b res=%h busy=%b, expected 1 0 0000 0",
                     in_ready, out_valid, alu_result, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready);
        end
        run_op(4'd0, 16'd3, 16'd4, 1'b0, 0, "add_after_reset");
    endtask

    task automatic test_single_cycle();
        logic [3:0]  ops[12] = '{4'd0, 4'd1, 4'd5, 4'd7, 4'd2, 4'd3, 4'd4, 4'd4, 4'd6, 4'd8, 4'd12, 4'd15};
        logic [15:0] av[12]  = '{16'hFFFF, 16'd2, 16'd1, 16'd10, 16'hA5A0, 16'hA5A0, 16'd3, 16'd9,
                                 16'h8000, 16'd2, 16'h1234, 16'hFFFF};
        logic [15:0] bv[12]  = '{16'd1, 16'd3, 16'h0013, 16'hFFF5, 16'h0F0F, 16'h0FF0, 16'd9, 16'd3,
                                 16'h00FF, 16'h00F3, 16'h5678, 16'hFFFF};
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], av[i], bv[i], 1'b0, 0, $sformatf("single_op%0d_%0d", ops[i], i));
        end
    endtask

    task automatic test_muldiv();
        run_op(4'd9,  16'h0123, 16'h0045, 1'b1, 0, "mul_held_valid");
        run_op(4'd10, 16'd100,  16'd7,    1'b0, 0, "divu_100_7");
        run_op(4'd11, 16'd100,  16'd7,    1'b0, 0, "remu_100_7");
        run_op(4'd10, 16'd5,    16'd0,    1'b0, 0, "divu_by_zero");
        run_op(4'd11, 16'd5,    16'd0,    1'b0, 0, "remu_by_zero");
        run_op(4'd9,  16'd3,    16'd3,    1'b0, 0, "mul_3_3");
        run_op(4'd9,  16'hFFFF, 16'hFFFF, 1'b0, 0, "mul_max");
        run_op(4'd10, 16'hFFFF, 16'd1,    1'b0, 0, "divu_max_1");
        run_op(4'd11, 16'd7,    16'd100,  1'b0, 0, "remu_small");
    endtask

    task automatic test_backpressure();
        run_op(4'd0, 16'h7FF0, 16'h0020, 1'b0, 5, "bp_add");
        run_op(4'd1, 16'd2,    16'd3,    1'b0, 5, "bp_sub_borrow");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic [3:0]  op;
            logic [15:0] x, y;
            op = 4'($urandom_range(0, 15));
            x  = 16'($urandom);
            y  = (i % 5 == 0) ? 16'd0 : 16'($urandom);
            run_op(op, x, y, 1'b0, 0, $sformatf("b2b%0d_op%0d", i, op));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_reset_mid_mul();
        test_single_cycle();
        test_muldiv();
        test_backpressure();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
